// File: rtl/dac_writer.sv
// dac_writer: SPI mode-0 DAC transmitter, 16-bit MSB-first frames over sck/mosi/cs_n.
// Define DAC_LDAC_EN to add the ldac_n port and a latch phase after the chip-select gap.
module dac_writer #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        mosi,
  output logic        sck,
  output logic        cs_n,
`ifdef DAC_LDAC_EN
  output logic        ldac_n,
`endif
  output logic        done
);
  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
`ifdef DAC_LDAC_EN
    , LATCH
`endif
  } state_t;
  state_t state;
  logic [7:0] hcnt;
  logic [4:0] bcnt;
  logic [3:0] gcnt;
  logic [15:0] shreg;
  logic last;
  assign last = hcnt == 8'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hcnt         <= '0;
      bcnt         <= '0;
      gcnt         <= '0;
      shreg        <= '0;
      sample_ready <= 1'b1;
      mosi         <= 1'b0;
      sck          <= 1'b0;
      cs_n         <= 1'b1;
      done         <= 1'b0;
`ifdef DAC_LDAC_EN
      ldac_n       <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      hcnt <= (state == IDLE || last) ? '0 : hcnt + 8'd1;
      case (state)
        IDLE: if (sample_valid) begin
          mosi         <= sample[15];
          shreg        <= {sample[14:0], 1'b0};
          cs_n         <= 1'b0;
          sample_ready <= 1'b0;
          state        <= SETUP;
        end
        SETUP: if (last) begin
          sck   <= 1'b1;
          bcnt  <= '0;
          state <= SHIFT;
        end
        // zero fill in shreg leaves mosi low after the 16th falling edge
        SHIFT: if (last) begin
          if (sck) begin
            sck   <= 1'b0;
            mosi  <= shreg[15];
            shreg <= {shreg[14:0], 1'b0};
          end else if (bcnt == 5'd15) begin
            state <= HOLD;
          end else begin
            sck  <= 1'b1;
            bcnt <= bcnt + 5'd1;
          end
        end
        HOLD: if (last) begin
          cs_n  <= 1'b1;
          done  <= 1'b1;
          gcnt  <= '0;
          state <= GAP;
        end
        GAP: if (last) begin
          if (gcnt == 4'(CS_GAP - 1)) begin
`ifdef DAC_LDAC_EN
            ldac_n <= 1'b0;
            state  <= LATCH;
`else
            sample_ready <= 1'b1;
            state        <= IDLE;
`endif
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
`ifdef DAC_LDAC_EN
        LATCH: if (last) begin
          ldac_n       <= 1'b1;
          sample_ready <= 1'b1;
          state        <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_writer.sv
// tb_dac_writer: random and directed frames on two dac_writer instances (H=4 and H=1),
// compared every cycle against a timeline model built from frame offsets.
module tb_dac_writer;
  localparam int H0 = 4, G0 = 1, H1 = 1, G1 = 3;
`ifdef DAC_LDAC_EN
  localparam int LT = 1;
`else
  localparam int LT = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] smp [2] = '{16'h0, 16'h0};
  logic vld [2] = '{1'b0, 1'b0};
  logic rdy [2], mosi [2], sck [2], cs_n [2], done [2];
`ifdef DAC_LDAC_EN
  logic ldac_n [2];
`endif
  logic [15:0] w [2];
  logic [15:0] cap0 = 16'h0, cap1 = 16'h0;
  int t [2] = '{-1, -1};
  int vectors = 0, miscompares = 0;
  int acc;

  always #5 clk = ~clk;

  dac_writer #(.CLK_DIV(H0), .CS_GAP(G0)) u0 (
    .clk(clk), .rst_n(rst_n), .sample(smp[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .mosi(mosi[0]), .sck(sck[0]), .cs_n(cs_n[0]),
`ifdef DAC_LDAC_EN
    .ldac_n(ldac_n[0]),
`endif
    .done(done[0]));

  dac_writer #(.CLK_DIV(H1), .CS_GAP(G1)) u1 (
    .clk(clk), .rst_n(rst_n), .sample(smp[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .mosi(mosi[1]), .sck(sck[1]), .cs_n(cs_n[1]),
`ifdef DAC_LDAC_EN
    .ldac_n(ldac_n[1]),
`endif
    .done(done[1]));

  function automatic int hh(int k);
    return k == 0 ? H0 : H1;
  endfunction

  function automatic int gg(int k);
    return k == 0 ? G0 : G1;
  endfunction

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // what the DAC sees on each SCK rise
  always @(posedge sck[0]) cap0 = {cap0[14:0], mosi[0]};
  always @(posedge sck[1]) cap1 = {cap1[14:0], mosi[1]};

  // t = cycles since the accept edge; frame ends (ready again) at tend
  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 2; k++) begin
      int tend;
      tend = (34 + gg(k) + LT) * hh(k);
      if (!rst_n) t[k] = -1;
      else if ((t[k] < 0 || t[k] >= tend) && vld[k]) begin
        t[k] = 0;
        w[k] = smp[k];
      end else if (t[k] >= 0 && t[k] < tend) t[k]++;
    end

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      int h, g, tt, tend, idx;
      logic idle, es, em;
      h = hh(k); g = gg(k); tt = t[k];
      tend = (34 + g + LT) * h;
      idle = tt < 0 || tt >= tend;
      es = !idle && tt >= h && tt < 33 * h && ((tt - h) / h) % 2 == 0;
      em = 1'b0;
      if (!idle && tt < h) em = w[k][15];
      else if (!idle && tt < 33 * h) begin
        idx = es ? 15 - (tt - h) / (2 * h) : 14 - (tt - h) / (2 * h);
        if (idx >= 0) em = w[k][idx[3:0]];
      end
      check($sformatf("u%0d t=%0d ready", k, tt), 16'(rdy[k]), 16'(idle));
      check($sformatf("u%0d t=%0d cs_n", k, tt), 16'(cs_n[k]), 16'(idle || tt >= 34 * h));
      check($sformatf("u%0d t=%0d sck", k, tt), 16'(sck[k]), 16'(es));
      check($sformatf("u%0d t=%0d mosi", k, tt), 16'(mosi[k]), 16'(em));
      check($sformatf("u%0d t=%0d done", k, tt), 16'(done[k]), 16'(!idle && tt == 34 * h));
`ifdef DAC_LDAC_EN
      check($sformatf("u%0d t=%0d ldac_n", k, tt), 16'(ldac_n[k]), 16'(idle || tt < (34 + g) * h));
`endif
      if (!idle && tt == 34 * h)
        check($sformatf("u%0d captured word", k), k == 0 ? cap0 : cap1, w[k]);
    end

  task automatic send(int k, logic [15:0] word);
    @(negedge clk); #1;
    smp[k] = word;
    vld[k] = 1'b1;
    @(negedge clk); #1;
    vld[k] = 1'b0;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    send(0, 16'hA5C3);
    send(1, 16'hFFFF);
    wait_cycles(160);
    // back-to-back with valid held high on u0
    @(negedge clk); #1;
    smp[0] = 16'h0001;
    vld[0] = 1'b1;
    acc = 0;
    for (int i = 0; i < 400 && acc < 2; i++) begin
      @(negedge clk); #1;
      if (t[0] == 0) begin
        acc++;
        smp[0] = 16'h8000;
      end
    end
    vld[0] = 1'b0;
    check("b2b accepts", 16'(acc), 16'd2);
    wait_cycles(160);
    // valid pulsed while busy is dropped
    send(0, 16'h00FF);
    wait_cycles(50);
    send(0, 16'h1234);
    wait_cycles(200);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        vld[k] = $urandom_range(0, 9) == 0;
        smp[k] = 16'($urandom);
      end
    end
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    wait_cycles(200);
    // reset shortly after the 7th SCK rise
    send(0, 16'($urandom));
    for (int i = 0; i < 200 && t[0] != 13 * H0 + 1; i++) @(negedge clk);
    check("rst wait", 16'(t[0]), 16'(13 * H0 + 1));
    #2 rst_n = 1'b0;
    #1;
    check("rst cs_n", 16'(cs_n[0]), 16'd1);
    check("rst sck", 16'(sck[0]), 16'd0);
    check("rst mosi", 16'(mosi[0]), 16'd0);
    check("rst done", 16'(done[0]), 16'd0);
    check("rst ready", 16'(rdy[0]), 16'd1);
    wait_cycles(2);
    #1 rst_n = 1'b1;
    send(0, 16'h5A3C);
    send(1, 16'hC001);
    wait_cycles(160);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
